// File: rtl/compute_arbiter_pkg.sv
// compute_arbiter_pkg: shared types and constants for the compute arbiter slice of the
// accelerator. Holds the operand/result types used between the processing units and the
// shared compute unit, the arbiter state encoding and a small pointer-wrap helper.
//
// Contents:
//   UNIT_COUNT, UNIT_ID_WIDTH  number of processing units and width of a unit index
//   ARB_TIMEOUT_DEFAULT        default WAIT watchdog limit (used with ARB_TIMEOUT_EN)
//   comp_type_e                operation type carried with each request
//   matrix_t, vector_t         operand and result payloads
//   arb_state_e                arbiter sequencing states
//   wrap_inc()                 index increment modulo a requester count
package compute_arbiter_pkg;

   localparam int unsigned UNIT_COUNT          = 4;
   localparam int unsigned UNIT_ID_WIDTH       = 2;
   localparam int unsigned ARB_TIMEOUT_DEFAULT = 256;

   localparam int unsigned ELEM_WIDTH = 8;
   localparam int unsigned MAT_DIM    = 2;

   typedef enum logic [1:0] {
      COMP_ADD = 2'd0,
      COMP_SUB = 2'd1,
      COMP_MUL = 2'd2,
      COMP_DOT = 2'd3
   } comp_type_e;

   // 2x2 operand of 8-bit elements; result is a 2-entry vector of 16-bit lanes.
   typedef logic [MAT_DIM*MAT_DIM-1:0][ELEM_WIDTH-1:0] matrix_t;
   typedef logic [MAT_DIM-1:0][2*ELEM_WIDTH-1:0]       vector_t;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_e;

   // Next index after idx, wrapping to 0 once n is reached (n need not be a power of two).
   function automatic logic [UNIT_ID_WIDTH-1:0] wrap_inc(input logic [UNIT_ID_WIDTH-1:0] idx,
                                                         input int unsigned              n);
      if (32'(idx) + 32'd1 >= n) begin
         return '0;
      end
      return idx + 1'b1;
   endfunction

endpackage

// File: rtl/compute_arbiter_picker.sv
// rr_priority_picker: combinational round-robin pick. Searches req_i starting at bit
// rr_ptr_i and moving upward, wrapping modulo N_REQ, and reports the first set bit.
//
// Parameters:
//   N_REQ   number of request lines
//   IDX_W   width of rr_ptr_i / idx_o; must be able to hold N_REQ-1
// Ports:
//   req_i     request levels
//   rr_ptr_i  index given highest priority
//   onehot_o  one-hot winner (zero when no request)
//   idx_o     index of the winner (zero when no request)
//   valid_o   at least one request present
module rr_priority_picker #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] rr_ptr_i,
   output logic [N_REQ-1:0] onehot_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      valid_o  = 1'b0;
      cand     = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = IDX_W'((32'(rr_ptr_i) + i) % N_REQ);
         if (!valid_o && req_i[cand]) begin
            valid_o        = 1'b1;
            onehot_o[cand] = 1'b1;
            idx_o          = cand;
         end
      end
   end

endmodule

// File: rtl/compute_arbiter.sv
// compute_arbiter: round-robin arbiter and sequencer sharing one compute unit among
// N_REQ processing units. Each transaction grants one requester, latches its operand and
// operation type, runs the request/ready/done handshake with the compute unit and returns
// the result to the owner with a one-cycle done pulse.
//
// Optional feature: define ARB_TIMEOUT_EN to add a WAIT watchdog. After TIMEOUT_CYCLES
// cycles without cu_done the transaction is closed with unit_err=1 and a zero result.
// Without the macro WAIT waits indefinitely and unit_err is tied low.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req/req_type/req_data      per-unit request level, operation type and operand
//   grant, owner_id            one-hot owner and its index (zero when idle)
//   unit_done, unit_err        one-cycle completion pulse to the owner; timeout qualifier
//   unit_result                result broadcast to all units, held until the next response
//   cu_request/cu_ready        issue handshake with the compute unit
//   cu_done/cu_result          completion and result from the compute unit
//   cu_comp_type, cu_data      operation type and operand latched at grant
//   busy                       any state other than idle
//   grant_count                saturating count of completed grants
module compute_arbiter
   import compute_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ          = UNIT_COUNT,
   parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  comp_type_e               req_type [N_REQ],
   input  matrix_t                  req_data [N_REQ],
   output logic [N_REQ-1:0]         grant,
   output logic [N_REQ-1:0]         unit_done,
   output vector_t                  unit_result,
   output logic                     unit_err,
   output logic                     cu_request,
   input  logic                     cu_ready,
   input  logic                     cu_done,
   output comp_type_e               cu_comp_type,
   output matrix_t                  cu_data,
   input  vector_t                  cu_result,
   output logic [UNIT_ID_WIDTH-1:0] owner_id,
   output logic                     busy,
   output logic [15:0]              grant_count
);

   localparam logic [1:0] StIdle  = ARB_IDLE;
   localparam logic [1:0] StIssue = ARB_ISSUE;
   localparam logic [1:0] StWait  = ARB_WAIT;
   localparam logic [1:0] StResp  = ARB_RESP;

   logic [1:0]               state_q, state_d;
   logic [N_REQ-1:0]         grant_q, grant_d;
   logic [UNIT_ID_WIDTH-1:0] owner_q, owner_d;
   logic [UNIT_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   comp_type_e               type_q, type_d;
   matrix_t                  data_q, data_d;
   logic                     cu_request_q, cu_request_d;
   logic [N_REQ-1:0]         unit_done_q, unit_done_d;
   vector_t                  result_q, result_d;
   logic [15:0]              count_q, count_d;

   logic [N_REQ-1:0]         pick_onehot;
   logic [UNIT_ID_WIDTH-1:0] pick_idx;
   logic                     pick_valid;

   rr_priority_picker #(
      .N_REQ (N_REQ),
      .IDX_W (UNIT_ID_WIDTH)
   ) u_picker (
      .req_i    (req),
      .rr_ptr_i (rr_ptr_q),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx),
      .valid_o  (pick_valid)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
   logic            timeout;
   logic            err_q, err_d;

   // Counter only advances in WAIT, so it is zero on every entry to WAIT.
   assign timeout = (state_q == StWait) && (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wd_cnt_d = '0;
      if (state_q == StWait) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         err_q    <= err_d;
      end
   end

   assign unit_err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign unit_err       = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      type_d       = type_q;
      data_d       = data_q;
      cu_request_d = cu_request_q;
      unit_done_d  = '0;
      result_d     = result_q;
      count_d      = count_q;
`ifdef ARB_TIMEOUT_EN
      err_d        = 1'b0;
`endif

      case (state_q)
         StIdle: begin
            // Operands are captured here so later req_data/req_type changes cannot leak
            // into the transaction in flight.
            if (pick_valid) begin
               grant_d      = pick_onehot;
               owner_d      = pick_idx;
               type_d       = req_type[pick_idx];
               data_d       = req_data[pick_idx];
               cu_request_d = 1'b1;
               state_d      = StIssue;
            end
         end

         StIssue: begin
            if (cu_ready) begin
               cu_request_d = 1'b0;
               state_d      = StWait;
            end
         end

         StWait: begin
            // grant_q is the owner's one-hot, so it doubles as the done pulse pattern.
            if (cu_done) begin
               result_d    = cu_result;
               unit_done_d = grant_q;
               state_d     = StResp;
`ifdef ARB_TIMEOUT_EN
            end else if (timeout) begin
               result_d    = '0;
               unit_done_d = grant_q;
               err_d       = 1'b1;
               state_d     = StResp;
`endif
            end
         end

         StResp: begin
            // The owner becomes lowest priority for the next arbitration.
            grant_d  = '0;
            rr_ptr_d = wrap_inc(owner_q, N_REQ);
            count_d  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            state_d  = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         type_q       <= COMP_ADD;
         data_q       <= '0;
         cu_request_q <= 1'b0;
         unit_done_q  <= '0;
         result_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         type_q       <= type_d;
         data_q       <= data_d;
         cu_request_q <= cu_request_d;
         unit_done_q  <= unit_done_d;
         result_q     <= result_d;
         count_q      <= count_d;
      end
   end

   assign grant        = grant_q;
   assign owner_id     = owner_q;
   assign cu_comp_type = type_q;
   assign cu_data      = data_q;
   assign cu_request   = cu_request_q;
   assign unit_done    = unit_done_q;
   assign unit_result  = result_q;
   assign grant_count  = count_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_compute_arbiter.sv
// Self-checking bench for compute_arbiter: table of single transactions plus hand-written
// sequences (async reset, continuous round-robin, owner drop, optional watchdog timeout).
// Expected done pulses are queued when cu_done is driven and checked by a monitor.
module tb_compute_arbiter;
   import compute_arbiter_pkg::*;

   localparam int unsigned NReq = 4;
   localparam int unsigned Tmo  = 16;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NReq-1:0]          req;
   comp_type_e               req_type [NReq];
   matrix_t                  req_data [NReq];
   logic [NReq-1:0]          grant;
   logic [NReq-1:0]          unit_done;
   vector_t                  unit_result;
   logic                     unit_err;
   logic                     cu_request;
   logic                     cu_ready;
   logic                     cu_done;
   comp_type_e               cu_comp_type;
   matrix_t                  cu_data;
   vector_t                  cu_result;
   logic [UNIT_ID_WIDTH-1:0] owner_id;
   logic                     busy;
   logic [15:0]              grant_count;

   compute_arbiter #(
      .N_REQ          (NReq),
      .TIMEOUT_CYCLES (Tmo)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .req_type     (req_type),
      .req_data     (req_data),
      .grant        (grant),
      .unit_done    (unit_done),
      .unit_result  (unit_result),
      .unit_err     (unit_err),
      .cu_request   (cu_request),
      .cu_ready     (cu_ready),
      .cu_done      (cu_done),
      .cu_comp_type (cu_comp_type),
      .cu_data      (cu_data),
      .cu_result    (cu_result),
      .owner_id     (owner_id),
      .busy         (busy),
      .grant_count  (grant_count)
   );

   always #5 clk = ~clk;

   int      checks   = 0;
   int      failures = 0;
   vector_t last_result;

   typedef struct packed {
      logic [NReq-1:0] done;
      vector_t         result;
      logic            err;
   } exp_t;

   exp_t sb_q[$];

   typedef struct {
      logic [NReq-1:0] mask;
      int              owner;
      int              rdy;
      int              dly;
      vector_t         res;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && unit_done != '0) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got 0x%0h expected none at %0t", unit_done, $time);
         end else begin
            e = sb_q.pop_front();
            check("done_mask", 64'(unit_done), 64'(e.done));
            check("done_result", 64'(unit_result), 64'(e.result));
            check("done_err", 64'(unit_err), 64'(e.err));
            check("done_busy", 64'(busy), 64'd1);
         end
      end
   end

   function automatic matrix_t mk_data(input int u, input int v);
      return {8'(v), 8'(u), 8'hA5, 8'(v * 3 + u)};
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_grant"}, 64'(grant), 64'd0);
      check({tag, "_unit_done"}, 64'(unit_done), 64'd0);
      check({tag, "_unit_result"}, 64'(unit_result), 64'd0);
      check({tag, "_unit_err"}, 64'(unit_err), 64'd0);
      check({tag, "_cu_request"}, 64'(cu_request), 64'd0);
      check({tag, "_cu_comp_type"}, 64'(cu_comp_type), 64'(COMP_ADD));
      check({tag, "_cu_data"}, 64'(cu_data), 64'd0);
      check({tag, "_owner_id"}, 64'(owner_id), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_grant_count"}, 64'(grant_count), 64'd0);
   endtask

   task automatic wait_grant(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (grant == '0 && n < 20);
   endtask

   // One full transaction; called at a negedge with the arbiter idle.
   task automatic run_txn(input logic [NReq-1:0] mask, input int owner, input int rdy_dly,
                          input int done_dly, input vector_t res, input bit drop_in_wait,
                          input bit clear_req, input int v);
      logic [NReq-1:0] exp_gnt;
      matrix_t         exp_data;
      comp_type_e      exp_type;
      int              n;
      int              req_hi;
      exp_gnt = NReq'(1) << owner;
      for (int u = 0; u < NReq; u++) begin
         req_type[u] = comp_type_e'((u + v) % 4);
         req_data[u] = mk_data(u, v);
      end
      exp_data = req_data[owner];
      exp_type = req_type[owner];
      req      = mask;
      wait_grant(n);
      check("grant_latency", 64'(n), 64'd1);
      check("grant", 64'(grant), 64'(exp_gnt));
      check("owner_id", 64'(owner_id), 64'(owner));
      check("cu_data_at_grant", 64'(cu_data), 64'(exp_data));
      check("cu_type_at_grant", 64'(cu_comp_type), 64'(exp_type));
      check("cu_request_issue", 64'(cu_request), 64'd1);
      check("result_held", 64'(unit_result), 64'(last_result));
      req_hi = 0;
      for (int c = 0; c < rdy_dly; c++) begin
         if (cu_request) req_hi++;
         for (int u = 0; u < NReq; u++) begin
            req_data[u] = matrix_t'($urandom());
            req_type[u] = comp_type_e'($urandom_range(0, 3));
         end
         @(negedge clk);
      end
      check("cu_request_hold", 64'(req_hi), 64'(rdy_dly));
      check("cu_data_latched", 64'(cu_data), 64'(exp_data));
      check("cu_type_latched", 64'(cu_comp_type), 64'(exp_type));
      cu_ready = 1'b1;
      @(negedge clk);
      cu_ready = 1'b0;
      check("cu_request_dropped", 64'(cu_request), 64'd0);
      if (drop_in_wait) req = req & ~exp_gnt;
      repeat (done_dly) @(negedge clk);
      check("grant_in_wait", 64'(grant), 64'(exp_gnt));
      check("no_early_done", 64'(unit_done), 64'd0);
      cu_result = res;
      cu_done   = 1'b1;
      sb_q.push_back('{done: exp_gnt, result: res, err: 1'b0});
      @(negedge clk);
      cu_done   = 1'b0;
      cu_result = vector_t'($urandom());
      #1;
      check("done_consumed", 64'(sb_q.size()), 64'd0);
      last_result = res;
      if (clear_req) req = '0;
      @(negedge clk);
      check("idle_grant", 64'(grant), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(unit_done), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[10];
      int   order[5];
      int   n;

      rst_n       = 1'b0;
      req         = '0;
      cu_ready    = 1'b0;
      cu_done     = 1'b0;
      cu_result   = '0;
      last_result = '0;
      for (int u = 0; u < NReq; u++) begin
         req_type[u] = COMP_ADD;
         req_data[u] = '0;
      end

      // Expected owners follow the round-robin pointer left by the previous transaction.
      tbl[0] = '{mask: 4'b0100, owner: 2, rdy: 0,  dly: 3, res: 32'h1111_0001};
      tbl[1] = '{mask: 4'b0101, owner: 0, rdy: 1,  dly: 0, res: 32'h2222_0002};
      tbl[2] = '{mask: 4'b1111, owner: 1, rdy: 10, dly: 2, res: 32'h3333_0003};
      tbl[3] = '{mask: 4'b1001, owner: 3, rdy: 0,  dly: 1, res: 32'h4444_0004};
      tbl[4] = '{mask: 4'b1000, owner: 3, rdy: 2,  dly: 0, res: 32'h5555_0005};
      tbl[5] = '{mask: 4'b0011, owner: 0, rdy: 0,  dly: 4, res: 32'h6666_0006};
      tbl[6] = '{mask: 4'b0001, owner: 0, rdy: 3,  dly: 1, res: 32'h7777_0007};
      tbl[7] = '{mask: 4'b0110, owner: 1, rdy: 0,  dly: 0, res: 32'h8888_0008};
      tbl[8] = '{mask: 4'b1010, owner: 3, rdy: 1,  dly: 2, res: 32'h9999_0009};
      tbl[9] = '{mask: 4'b1110, owner: 1, rdy: 0,  dly: 1, res: 32'hAAAA_000A};

      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Unit 2 alone, immediate ready, done five cycles into WAIT.
      run_txn(4'b0100, 2, 0, 4, 32'h0012_0034, 1'b0, 1'b1, 0);
      check("count_single", 64'(grant_count), 64'd1);

      for (int i = 0; i < 10; i++) begin
         run_txn(tbl[i].mask, tbl[i].owner, tbl[i].rdy, tbl[i].dly, tbl[i].res, 1'b0, 1'b1,
                 i + 1);
      end
      check("count_table", 64'(grant_count), 64'd11);

      // Asynchronous reset while waiting on the compute unit.
      req = 4'b0010;
      wait_grant(n);
      check("rst_txn_grant", 64'(grant), 64'b0010);
      cu_ready = 1'b1;
      @(negedge clk);
      cu_ready = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      req         = '0;
      rst_n       = 1'b1;
      last_result = '0;
      @(negedge clk);
      run_txn(4'b1000, 3, 0, 1, 32'hBEEF_0001, 1'b0, 1'b1, 30);
      check("count_after_rst", 64'(grant_count), 64'd1);

      // All four requesting continuously: pointer is back at 0.
      order = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
         run_txn(4'b1111, order[i], 0, 1, vector_t'(32'hC000_0000 + i), 1'b0, i == 4, 40 + i);
      end
      check("count_rr", 64'(grant_count), 64'd6);

      // Owner drops its request in WAIT: it still completes and is not granted again.
      run_txn(4'b0010, 1, 0, 2, 32'hD00D_0001, 1'b1, 1'b0, 50);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("drop_no_regrant", 64'(grant), 64'd0);
      end
      check("drop_idle_busy", 64'(busy), 64'd0);
      check("count_drop", 64'(grant_count), 64'd7);

`ifdef ARB_TIMEOUT_EN
      req = 4'b0100;
      wait_grant(n);
      check("tmo_grant", 64'(grant), 64'b0100);
      cu_ready  = 1'b1;
      cu_result = 32'hFFFF_FFFF;
      @(negedge clk);
      cu_ready = 1'b0;
      repeat (Tmo - 1) @(negedge clk);
      check("tmo_not_early", 64'(unit_done), 64'd0);
      check("tmo_still_busy", 64'(busy), 64'd1);
      sb_q.push_back('{done: 4'b0100, result: '0, err: 1'b1});
      @(negedge clk);
      #1;
      check("tmo_done_consumed", 64'(sb_q.size()), 64'd0);
      req = '0;
      @(negedge clk);
      check("tmo_idle_busy", 64'(busy), 64'd0);
      check("tmo_err_cleared", 64'(unit_err), 64'd0);
      check("count_tmo", 64'(grant_count), 64'd8);
`endif

      repeat (3) @(negedge clk);
      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/compute_arbiter.md
# compute_arbiter

Round-robin arbiter and sequencer that shares the single `shared_compute_unit` among all `UNIT_COUNT` processing units. It sits between the processing units and the shared compute unit in `accelerator_top`. Each transaction follows the same sequence: grant one requester, latch its operands and operation type, drive the request/ready/done handshake with the compute unit, then return the result to the granted unit with a one-cycle done pulse. It replaces the hard-wired unit-0 connection and gives every unit fair access.

## Interface
Parameters:
- `N_REQ`, default `UNIT_COUNT` (4): number of requesters.
- `TIMEOUT_CYCLES`, default 256: watchdog limit in the WAIT state. Used only with `ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-unit request level; held until that unit's `unit_done` pulse.
- `req_type`  in  comp_type_e[N_REQ]  per-unit operation type.
- `req_data`  in  matrix_t[N_REQ]  per-unit operand.
- `grant`  out  N_REQ  one-hot owner; zero when idle.
- `unit_done`  out  N_REQ  one-cycle completion pulse to the owner.
- `unit_result`  out  vector_t  result, broadcast to all units; valid while `unit_done` is non-zero.
- `unit_err`  out  1  qualifies `unit_done` as a timeout abort.
- `cu_request`  out  1  request to the shared compute unit.
- `cu_ready`  in  1  compute unit accepts the request.
- `cu_done`  in  1  compute unit finished.
- `cu_comp_type`  out  comp_type_e  latched operation type.
- `cu_data`  out  matrix_t  latched operand.
- `cu_result`  in  vector_t  compute unit result; valid with `cu_done`.
- `owner_id`  out  UNIT_ID_WIDTH  index of the current owner.
- `busy`  out  1  high in any state other than IDLE.
- `grant_count`  out  16  saturating count of completed grants.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, when `req` is non-zero:
  - pick the first asserted bit, searching from `rr_ptr` upward and wrapping modulo N_REQ;
  - register the choice in `grant` and `owner_id`;
  - latch `req_type` and `req_data` of the winner into `cu_comp_type` and `cu_data`;
  - go to ISSUE.
- ISSUE: hold `cu_request`=1. On the edge where `cu_request & cu_ready`, go to WAIT and drop `cu_request`.
- WAIT: on `cu_done`, capture `cu_result` into `unit_result` and go to RESP.
- RESP:
  - `unit_done[owner_id]`=1 for exactly one cycle;
  - `rr_ptr` ← (owner_id+1) mod N_REQ;
  - `grant_count` increments, saturating at 0xFFFF;
  - clear `grant`; go to IDLE.
- Fairness: the owner has lowest priority in the next arbitration. With all N_REQ units requesting continuously, each unit is served once every N_REQ transactions.
- Operands are latched at grant. Later changes to `req_data` or `req_type` do not affect the transaction in flight.
- If the owner deasserts `req` mid-transaction, the transaction still completes and `unit_done` still pulses. There is no abort path.
- Requests that arrive in ISSUE, WAIT or RESP wait for the next IDLE arbitration.
- `cu_done` outside WAIT is ignored.
- `cu_ready` outside ISSUE is ignored.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, and every output 0 (`grant`, `unit_done`, `unit_result`, `unit_err`, `cu_request`, `cu_comp_type`=COMP_ADD, `cu_data`, `owner_id`, `busy`, `grant_count`).
- Reset mid-transaction returns to IDLE immediately and asynchronously. `cu_request` drops and no `unit_done` is issued.
- `req` rising in IDLE at edge k gives `grant` and `cu_request` high after edge k+1.
- `cu_ready` sampled at edge m moves the FSM to WAIT after m. `cu_done` sampled at edge d pulses `unit_done` during cycle d+1. IDLE follows at d+2.
- Minimum per-transaction overhead: 3 cycles plus compute latency. Back-to-back grants are separated by exactly one IDLE cycle.
- `unit_result` holds its last value until the next RESP.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - a counter runs in WAIT;
  - if `cu_done` is absent for TIMEOUT_CYCLES cycles, go to RESP with `unit_err`=1 and `unit_result`=0;
  - the owner still gets its `unit_done` pulse;
  - the counter clears on every entry to WAIT.
- `ARB_TIMEOUT_EN` undefined: no counter; WAIT waits indefinitely; `unit_err` is tied to 0.

## Structure
- Add to `accel_pkg`:
  - `arb_state_e` (IDLE, ISSUE, WAIT, RESP);
  - `ARB_TIMEOUT_DEFAULT`=256.
- Reuse `comp_type_e`, `matrix_t`, `vector_t` and `UNIT_ID_WIDTH` from `accel_pkg`.
- One sub-module, `rr_priority_picker`: combinational rotate-and-pick with inputs `req` and `rr_ptr`, outputs a one-hot and an index. Keeps the FSM file focused on sequencing.

## Test plan
- Single requester: unit 2 requests ADD, `cu_ready` is immediate, `cu_done` 5 cycles later → `grant`=0b0100, `unit_done[2]` pulses once, `unit_result` equals `cu_result`, `grant_count`=1.
- All four units request continuously → grant order 0,1,2,3,0. No unit is granted twice before all four have been served.
- `cu_ready` held low for 10 cycles → `cu_request` stays high for 10 cycles, and `cu_data` stays equal to the value latched at grant even though `req_data` changes.
- Owner drops `req` in WAIT → the transaction completes, `unit_done` pulses, the next arbitration excludes that unit.
- `rst_n` asserted in WAIT → all outputs are 0 asynchronously. After release, a new request is granted normally.
- With `ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=16, `cu_done` never arrives → after 16 WAIT cycles, `unit_done` and `unit_err` pulse together with `unit_result`=0, and the FSM returns to IDLE.
